residual_out_buf: RTL and testbench
===================================

// Module: residual_out_buf
// PURPOSE
//  Holds inverse-transformed 4x4 inter residual blocks between the residual/transform stage and the
//  inter reconstruction (pred+residual sum) stage. Up to 24 blocks per MB (16 luma, 4 Cb, 4 Cr).
//  The residual controller supplies the write strobe and both block indices; this block generates the read strobe.
//  Tracks which entries are filled, and gives the consumer a valid/ready read handshake.
// PARAMETERS
//  DATA_W   9    bits per residual sample (signed, two's complement)
//  NUM_BLK  24   block entries per MB
//  ADDR_W   5    block index width
// PORTS
//  clk           in   1            clock
//  rst_n         in   1            async reset, active low
//  ena           in   1            global enable; when 0 all state holds
//  start_of_MB   in   1            one-cycle pulse, new MB
//  wr            in   1            store strobe (transform done, inter MB, non-DC pass)
//  wr_addr       in   ADDR_W       block index for the write (controller's write counter)
//  wr_data       in   16*DATA_W    4x4 residual block, sample 0 in LSBs, raster order
//  rd_addr       in   ADDR_W       block index to read (controller's read counter)
//  rd_ready      in   1            consumer can accept a block
//  out_ram_rd    out  1            pop strobe to controller; advances its read counter
//  rd_data       out  16*DATA_W    registered block output
//  rd_valid      out  1            rd_data valid; one-cycle pulse per popped block
//  blk_cnt       out  ADDR_W+1     number of filled, unread entries (0..NUM_BLK)
//  ovf_err       out  1            sticky: write to an already filled entry, or wr_addr >= NUM_BLK
// BEHAVIOUR
//  Reset:
//   - filled bitmap = 0; blk_cnt = 0; rd_data = 0; rd_valid = 0; ovf_err = 0.
//   - Memory contents are not reset.
//  ena = 0:
//   - No state change; out_ram_rd forced 0; rd_valid forced 0.
//  Write: on wr && ena, mem[wr_addr] <= wr_data and filled[wr_addr] <= 1.
//  Read decision (combinational):
//   - out_ram_rd = ena && rd_ready && filled[rd_addr] && rd_addr < NUM_BLK.
//   - Uses the registered bitmap. A write in the same cycle to rd_addr is not visible until the next cycle; no forwarding.
//  Read data:
//   - On out_ram_rd: rd_data <= mem[rd_addr], rd_valid <= 1, filled[rd_addr] <= 0.
//   - Latency is 1 cycle from out_ram_rd to rd_valid. rd_data holds until the next pop.
//  Handshake: the consumer keeps rd_ready high until rd_valid is seen. Back-to-back pops are allowed, one block per cycle.
//  blk_cnt:
//   - +1 on wr only; -1 on pop only; unchanged on both in the same cycle.
//   - Saturates at NUM_BLK; never underflows.
//  Simultaneous write and pop, different entries: both take effect.
//  Simultaneous write and pop, same entry:
//   - Pop returns the old contents; the write fills the entry again.
//   - filled stays 1. Not an error.
//  Overflow: wr to a filled entry (not popped this cycle), or wr_addr >= NUM_BLK:
//   - Sets ovf_err (sticky until reset).
//   - An in-range overwrite still occurs; an out-of-range write is dropped.
//  start_of_MB:
//   - Clears the filled bitmap and blk_cnt; blocks pop that cycle.
//   - A wr in the same cycle is applied after the clear (entry ends filled, blk_cnt = 1).
//   - rd_valid from a pop in the previous cycle is still delivered.
//  Reset mid-MB: all tracking returns to reset values immediately (asynchronous).
//  Empty (filled[rd_addr] = 0): out_ram_rd stays 0 and the consumer stalls; no timeout.
// TESTING
//  1. Write blocks 0..23 (data = index replicated), then rd_ready=1 reading 0..23 -> 24 pops;
//     rd_valid 1 cycle after each pop; data matches; blk_cnt 24 -> 0.
//  2. rd_ready=1, block 5 unwritten -> out_ram_rd=0; write block 5 in cycle t ->
//     out_ram_rd=1 at t+1, rd_valid at t+2.
//  3. Write and pop of index 3 in the same cycle with entry 3 already filled ->
//     pop returns old data; filled[3]=1; blk_cnt unchanged; ovf_err=0.
//  4. Write index 7 twice without a pop -> ovf_err=1 after the 2nd write; blk_cnt=1.
//     Write index 24 -> dropped, ovf_err stays 1.
//  5. Write 10 blocks, pulse start_of_MB with a wr to index 0 -> blk_cnt=1; only entry 0 poppable.
//  6. Deassert ena for 3 cycles during back-to-back pops -> no out_ram_rd/rd_valid; resumes at the same index.
//     Assert rst_n=0 mid-stream -> all outputs 0.

Source files
------------

// File: rtl/residual_out_buf.sv
// residual_out_buf: per-MB store for inverse-transformed 4x4 inter residual blocks.
// The residual controller writes blocks by index. The consumer pops them through a
// valid/ready handshake, and out_ram_rd tells the controller to advance its read counter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 global enable; all state holds while low
//   start_of_MB         one-cycle pulse that clears the fill tracking for a new MB
//   wr/wr_addr/wr_data  block store from the transform stage
//   rd_addr, rd_ready   controller's read index, consumer ready
//   out_ram_rd          combinational pop strobe (advances controller read counter)
//   rd_data, rd_valid   registered block output, one-cycle valid pulse per pop
//   blk_cnt             filled-and-unread entry count
//   ovf_err             sticky overwrite / out-of-range write flag
module residual_out_buf #(
    parameter int unsigned DATA_W  = 9,
    parameter int unsigned NUM_BLK = 24,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   start_of_MB,
    input  logic                   wr,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [16*DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_ready,
    output logic                   out_ram_rd,
    output logic [16*DATA_W-1:0]   rd_data,
    output logic                   rd_valid,
    output logic [ADDR_W:0]        blk_cnt,
    output logic                   ovf_err
);

    localparam int unsigned BLK_W = 16 * DATA_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [BLK_W-1:0]   mem [NUM_BLK];
    logic [NUM_BLK-1:0] filled_q, filled_base, filled_d;
    logic [CNT_W-1:0]   cnt_base, cnt_d;
    logic               rd_valid_q;
    logic               rd_in_range, wr_in_range;
    logic               pop, wr_ok, same_entry, wr_hit, wr_new, ovf_set;

    // Pop/write decisions use the registered bitmap only; a write is never forwarded to a read.
    always_comb begin
        rd_in_range = 32'(rd_addr) < NUM_BLK;
        wr_in_range = 32'(wr_addr) < NUM_BLK;
        filled_base = start_of_MB ? '0 : filled_q;
        cnt_base    = start_of_MB ? '0 : blk_cnt;

        pop        = ena && rd_ready && !start_of_MB && rd_in_range && filled_q[rd_addr];
        wr_ok      = ena && wr && wr_in_range;
        same_entry = pop && (rd_addr == wr_addr);
        wr_hit     = wr_in_range && filled_base[wr_addr];
        // A write refilling the entry popped this cycle counts as a fresh fill, not an overwrite.
        wr_new     = wr_ok && (!wr_hit || same_entry);
        ovf_set    = ena && wr && (!wr_in_range || (wr_hit && !same_entry));

        filled_d = filled_base;
        if (pop)   filled_d[rd_addr] = 1'b0;
        if (wr_ok) filled_d[wr_addr] = 1'b1;

        cnt_d = cnt_base;
        if (wr_new && !pop && cnt_base < CNT_W'(NUM_BLK)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end else if (pop && !wr_new && cnt_base != '0) begin
            cnt_d = cnt_base - CNT_W'(1);
        end
    end

    assign out_ram_rd = pop;
    // A pending valid pulse is held through ena=0 and delivered once ena returns.
    assign rd_valid   = rd_valid_q && ena;

    // Block storage: not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    // Fill tracking, output register, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled_q   <= '0;
            blk_cnt    <= '0;
            rd_data    <= '0;
            rd_valid_q <= 1'b0;
            ovf_err    <= 1'b0;
        end else if (ena) begin
            filled_q   <= filled_d;
            blk_cnt    <= cnt_d;
            rd_valid_q <= pop;
            if (pop)     rd_data <= mem[rd_addr];
            if (ovf_set) ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_residual_out_buf.sv
// Directed testbench for residual_out_buf.
module tb_residual_out_buf;

    localparam int unsigned DATA_W  = 9;
    localparam int unsigned NUM_BLK = 24;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned BLK_W   = 16 * DATA_W;

    logic               clk = 1'b0;
    logic               rst_n, ena, start_of_MB, wr, rd_ready;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [BLK_W-1:0]   wr_data, rd_data;
    logic               out_ram_rd, rd_valid, ovf_err;
    logic [ADDR_W:0]    blk_cnt;

    int ntests = 0;
    int nfail  = 0;

    residual_out_buf #(.DATA_W(DATA_W), .NUM_BLK(NUM_BLK), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start_of_MB(start_of_MB),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_ready(rd_ready),
        .out_ram_rd(out_ram_rd), .rd_data(rd_data), .rd_valid(rd_valid),
        .blk_cnt(blk_cnt), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [BLK_W-1:0] blk(input int v);
        logic [DATA_W-1:0] s;
        s = DATA_W'(v);
        return {16{s}};
    endfunction

    task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_blk(input int a, input int v);
        wr = 1'b1; wr_addr = ADDR_W'(a); wr_data = blk(v);
        step();
        wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; start_of_MB = 1'b0; wr = 1'b0; rd_ready = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        #1;
        chk("rst_blk_cnt", BLK_W'(blk_cnt), '0);
        chk("rst_rd_valid", BLK_W'(rd_valid), '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_ovf", BLK_W'(ovf_err), '0);
        step(); step();
        rst_n = 1'b1; ena = 1'b1;

        // 1: fill all 24 entries, then pop them back to back
        for (int i = 0; i < 24; i++) write_blk(i, i);
        chk("t1_cnt_full", BLK_W'(blk_cnt), BLK_W'(24));
        rd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rd_addr = ADDR_W'(i);
            #1 chk($sformatf("t1_pop%0d", i), BLK_W'(out_ram_rd), BLK_W'(1));
            step();
            chk($sformatf("t1_valid%0d", i), BLK_W'(rd_valid), BLK_W'(1));
            chk($sformatf("t1_data%0d", i), rd_data, blk(i));
        end
        chk("t1_cnt_empty", BLK_W'(blk_cnt), '0);

        // 2: stall on empty entry 5, then write it; no same-cycle forwarding
        rd_addr = 5'd5;
        #1 chk("t2_stall", BLK_W'(out_ram_rd), '0);
        step();
        chk("t2_no_valid", BLK_W'(rd_valid), '0);
        wr = 1'b1; wr_addr = 5'd5; wr_data = blk(55);
        #1 chk("t2_no_fwd", BLK_W'(out_ram_rd), '0);
        step();
        wr = 1'b0;
        #1 chk("t2_pop_t1", BLK_W'(out_ram_rd), BLK_W'(1));
        step();
        rd_ready = 1'b0;
        chk("t2_valid_t2", BLK_W'(rd_valid), BLK_W'(1));
        chk("t2_data", rd_data, blk(55));

        // 3: write and pop entry 3 in the same cycle
        write_blk(3, 3);
        chk("t3_cnt1", BLK_W'(blk_cnt), BLK_W'(1));
        wr = 1'b1; wr_addr = 5'd3; wr_data = blk(100);
        rd_ready = 1'b1; rd_addr = 5'd3;
        #1 chk("t3_pop", BLK_W'(out_ram_rd), BLK_W'(1));
        step();
        wr = 1'b0; rd_ready = 1'b0;
        chk("t3_old_data", rd_data, blk(3));
        chk("t3_cnt_same", BLK_W'(blk_cnt), BLK_W'(1));
        chk("t3_no_ovf", BLK_W'(ovf_err), '0);
        rd_ready = 1'b1;
        #1 chk("t3_still_filled", BLK_W'(out_ram_rd), BLK_W'(1));
        step();
        rd_ready = 1'b0;
        chk("t3_new_data", rd_data, blk(100));
        chk("t3_cnt0", BLK_W'(blk_cnt), '0);

        // 4: overwrite and out-of-range write
        write_blk(7, 7);
        chk("t4_no_ovf_first", BLK_W'(ovf_err), '0);
        write_blk(7, 70);
        chk("t4_ovf", BLK_W'(ovf_err), BLK_W'(1));
        chk("t4_cnt", BLK_W'(blk_cnt), BLK_W'(1));
        write_blk(24, 99);
        chk("t4_ovf_sticky", BLK_W'(ovf_err), BLK_W'(1));
        chk("t4_cnt_drop", BLK_W'(blk_cnt), BLK_W'(1));
        rd_ready = 1'b1; rd_addr = 5'd7;
        step();
        rd_ready = 1'b0;
        chk("t4_overwritten", rd_data, blk(70));
        chk("t4_cnt0", BLK_W'(blk_cnt), '0);

        // 5: start_of_MB clears tracking, same-cycle write survives
        for (int i = 0; i < 10; i++) write_blk(i, 200 + i);
        chk("t5_cnt10", BLK_W'(blk_cnt), BLK_W'(10));
        start_of_MB = 1'b1; wr = 1'b1; wr_addr = 5'd0; wr_data = blk(42);
        rd_ready = 1'b1; rd_addr = 5'd0;
        #1 chk("t5_pop_blocked", BLK_W'(out_ram_rd), '0);
        step();
        start_of_MB = 1'b0; wr = 1'b0;
        chk("t5_cnt1", BLK_W'(blk_cnt), BLK_W'(1));
        chk("t5_no_valid", BLK_W'(rd_valid), '0);
        rd_addr = 5'd1;
        #1 chk("t5_e1_cleared", BLK_W'(out_ram_rd), '0);
        rd_addr = 5'd0;
        #1 chk("t5_e0_poppable", BLK_W'(out_ram_rd), BLK_W'(1));
        step();
        rd_ready = 1'b0;
        chk("t5_data", rd_data, blk(42));
        chk("t5_cnt0", BLK_W'(blk_cnt), '0);

        // 6: ena pause during back-to-back pops, then reset mid-stream
        for (int i = 0; i < 6; i++) write_blk(i, 300 + i);
        rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_addr = ADDR_W'(i);
            step();
        end
        ena = 1'b0; rd_addr = 5'd2;
        #1 chk("t6_valid_gated", BLK_W'(rd_valid), '0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_hold_pop%0d", i), BLK_W'(out_ram_rd), '0);
            chk($sformatf("t6_hold_valid%0d", i), BLK_W'(rd_valid), '0);
            step();
        end
        ena = 1'b1;
        #1 chk("t6_resume_pop", BLK_W'(out_ram_rd), BLK_W'(1));
        chk("t6_late_valid", BLK_W'(rd_valid), BLK_W'(1));
        chk("t6_late_data", rd_data, blk(301));
        step();
        chk("t6_resume_data", rd_data, blk(302));
        rd_addr = 5'd3;
        step();
        rd_addr = 5'd4;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pop", BLK_W'(out_ram_rd), '0);
        chk("t6_rst_valid", BLK_W'(rd_valid), '0);
        chk("t6_rst_data", rd_data, '0);
        chk("t6_rst_cnt", BLK_W'(blk_cnt), '0);
        chk("t6_rst_ovf", BLK_W'(ovf_err), '0);
        rd_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
